// File: rtl/ocp_arb2_pkg.sv
// Shared encodings and types for the two-master OCP arbiter.
package ocp_arb2_pkg;

  // OCP command encodings
  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  // OCP response encodings
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  // Arbitration policies
  localparam int unsigned ARB_RR      = 0;
  localparam int unsigned ARB_FIXED_D = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_t;

endpackage

// File: rtl/ocp_arb2_arb_rr2.sv
// Two-way request picker: round-robin or fixed priority to D. Purely combinational.
module arb_rr2
  import ocp_arb2_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  mst_t       last_gnt,
  input  logic       mode,
  output logic [1:0] gnt
);

  // gnt[0] selects I, gnt[1] selects D
  always_comb begin
    gnt = 2'b00;
    if (req_i && req_d) begin
      gnt = (mode || (last_gnt == MST_I)) ? 2'b10 : 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end else if (req_i) begin
      gnt = 2'b01;
    end
  end

endmodule

// File: rtl/ocp_arb2.sv
// Two-master (I, D) to one-slave OCP arbiter, one outstanding transaction,
// zero-latency command forwarding and a response watchdog.
module ocp_arb2
  import ocp_arb2_pkg::*;
#(
  parameter int unsigned ARB_MODE   = 0,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TMR_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_I_MAddr,
  input  logic [2:0]            i_I_MCmd,
  input  logic [DATA_WIDTH-1:0] i_I_MData,
  input  logic [BEN_WIDTH-1:0]  i_I_MByteEn,
  output logic                  o_I_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_I_SData,
  output logic [1:0]            o_I_SResp,
  input  logic [ADDR_WIDTH-1:0] i_D_MAddr,
  input  logic [2:0]            i_D_MCmd,
  input  logic [DATA_WIDTH-1:0] i_D_MData,
  input  logic [BEN_WIDTH-1:0]  i_D_MByteEn,
  output logic                  o_D_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_D_SData,
  output logic [1:0]            o_D_SResp,
  output logic [ADDR_WIDTH-1:0] o_P_MAddr,
  output logic [2:0]            o_P_MCmd,
  output logic [DATA_WIDTH-1:0] o_P_MData,
  output logic [BEN_WIDTH-1:0]  o_P_MByteEn,
  input  logic                  i_P_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P_SData,
  input  logic [1:0]            i_P_SResp
);

  state_t               state_q, state_d;
  mst_t                 owner_q, owner_d;
  mst_t                 last_gnt_q, last_gnt_d;
  logic [TMR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  req_i, req_d;
  logic [1:0]            gnt;
  logic                  tmo;
  logic                  owner_req;
  logic                  fwd;
  mst_t                  sel;
  logic                  acc;
  logic [1:0]            resp;
  logic [DATA_WIDTH-1:0] sdata;

  assign req_i     = (i_I_MCmd != CMD_IDLE);
  assign req_d     = (i_D_MCmd != CMD_IDLE);
  assign owner_req = (owner_q == MST_D) ? req_d : req_i;
  assign tmo       = (TIMEOUT != 0) && (cnt_q == TMR_WIDTH'(TIMEOUT));

  arb_rr2 u_pick (
    .req_i    (req_i),
    .req_d    (req_d),
    .last_gnt (last_gnt_q),
    .mode     (ARB_MODE == ARB_FIXED_D),
    .gnt      (gnt)
  );

  // State, ownership and watchdog registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      owner_q    <= MST_I;
      last_gnt_q <= MST_D;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state, grant, command forwarding and response routing
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    fwd        = 1'b0;
    sel        = owner_q;
    acc        = 1'b0;
    resp       = RESP_NULL;
    sdata      = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          sel        = gnt[1] ? MST_D : MST_I;
          fwd        = 1'b1;
          owner_d    = sel;
          last_gnt_d = sel;
          if (i_P_SCmdAccept) begin
            acc = 1'b1;
            if (i_P_SResp != RESP_NULL) begin
              resp  = i_P_SResp;
              sdata = i_P_SData;
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        if (!owner_req) begin
          // owner withdrew its command: abandon quietly
          state_d = ST_IDLE;
        end else begin
          fwd = 1'b1;
          if (tmo) begin
            acc     = 1'b1;
            resp    = RESP_ERR;
            state_d = ST_IDLE;
          end else if (i_P_SCmdAccept) begin
            acc = 1'b1;
            if (i_P_SResp != RESP_NULL) begin
              resp    = i_P_SResp;
              sdata   = i_P_SData;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            cnt_d = TMR_WIDTH'(cnt_q + 1'b1);
          end
        end
      end
      ST_RESP: begin
        if (tmo) begin
          resp    = RESP_ERR;
          state_d = ST_IDLE;
        end else if (i_P_SResp != RESP_NULL) begin
          resp    = i_P_SResp;
          sdata   = i_P_SData;
          state_d = ST_IDLE;
        end else begin
          cnt_d = TMR_WIDTH'(cnt_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // all outputs idle while reset is held
    if (!nrst) begin
      fwd   = 1'b0;
      acc   = 1'b0;
      resp  = RESP_NULL;
      sdata = '0;
    end
  end

  // Slave-side command mux
  always_comb begin
    o_P_MCmd    = CMD_IDLE;
    o_P_MAddr   = '0;
    o_P_MData   = '0;
    o_P_MByteEn = '0;
    if (fwd) begin
      if (sel == MST_D) begin
        o_P_MCmd    = i_D_MCmd;
        o_P_MAddr   = i_D_MAddr;
        o_P_MData   = i_D_MData;
        o_P_MByteEn = i_D_MByteEn;
      end else begin
        o_P_MCmd    = i_I_MCmd;
        o_P_MAddr   = i_I_MAddr;
        o_P_MData   = i_I_MData;
        o_P_MByteEn = i_I_MByteEn;
      end
    end
  end

  // Master-side response demux: only the selected master sees accept/response
  always_comb begin
    o_I_SCmdAccept = acc && (sel == MST_I);
    o_I_SResp      = (sel == MST_I) ? resp : RESP_NULL;
    o_I_SData      = (sel == MST_I) ? sdata : '0;
    o_D_SCmdAccept = acc && (sel == MST_D);
    o_D_SResp      = (sel == MST_D) ? resp : RESP_NULL;
    o_D_SData      = (sel == MST_D) ? sdata : '0;
  end

endmodule
